// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: frame format enums, arbiter state and pointer sizing.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    uart_5 = 3'd0,
    uart_6 = 3'd1,
    uart_7 = 3'd2,
    uart_8 = 3'd3,
    uart_9 = 3'd4
  } uart_size;

  typedef enum logic [1:0] {
    uart_9600   = 2'd0,
    uart_19200  = 2'd1,
    uart_57600  = 2'd2,
    uart_115200 = 2'd3
  } uart_freq;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } uart_arb_state_t;

  localparam int ARB_DATA_W = 9;
  localparam int ARB_SIZE_W = 3;

  // Pointer width; a single requester still gets a 1-bit pointer.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the arbiter; master = arbiter, slave = environment.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4
);
  localparam int IDX_W = arb_idx_w(N);
  localparam int FW    = $bits(uart_freq);

  // valid/ready: a requester holds valid and its frame fields stable until the
  // single-cycle o_req_ready pulse on its lane; that pulse is the acceptance.
  logic [N-1:0]            i_req_valid;
  logic [N*ARB_DATA_W-1:0] i_req_data;
  logic [N*ARB_SIZE_W-1:0] i_req_size;
  logic [N*FW-1:0]         i_req_freq;
  logic [N-1:0]            i_req_lock;
  logic [N-1:0]            o_req_ready;
  logic [N-1:0]            o_grant;
  logic                    o_busy;
  logic                    o_tx_we;
  logic [ARB_DATA_W-1:0]   o_tx_data;
  uart_size                o_tx_size;
  uart_freq                o_tx_freq;
  logic                    i_tx_done;
  uart_arb_state_t         o_dbg_state;
  logic [IDX_W-1:0]        o_dbg_ptr;

  modport master (
    input  i_req_valid, i_req_data, i_req_size, i_req_freq, i_req_lock, i_tx_done,
    output o_req_ready, o_grant, o_busy, o_tx_we, o_tx_data, o_tx_size, o_tx_freq,
    output o_dbg_state, o_dbg_ptr
  );

  modport slave (
    output i_req_valid, i_req_data, i_req_size, i_req_freq, i_req_lock, i_tx_done,
    input  o_req_ready, o_grant, o_busy, o_tx_we, o_tx_data, o_tx_size, o_tx_freq,
    input  o_dbg_state, o_dbg_ptr
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of valid_i starting at ptr_i, wrapping mod N.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]               valid_i,
  input  logic [arb_idx_w(N)-1:0]    ptr_i,
  output logic [arb_idx_w(N)-1:0]    idx_o,
  output logic                       found_o
);
  localparam int IDX_W = arb_idx_w(N);

  logic [IDX_W-1:0] k;

  // Scan from the farthest offset down so the nearest valid lane is written last.
  always_comb begin
    idx_o = '0;
    k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IDX_W'((int'(ptr_i) + i) % N);
      if (valid_i[k]) idx_o = k;
    end
  end

  assign found_o = |valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N requesters.
// Optional macro UART_TX_ARB_LOCK_EN: a locked owner is re-granted on done for back-to-back frames.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IDX_W = arb_idx_w(N);
  localparam int FW    = $bits(uart_freq);

  uart_arb_state_t       state_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      winner_q;
  logic [N-1:0]          grant_q;
  logic [N-1:0]          ready_q;
  logic                  busy_q;
  logic                  we_q;
  logic [ARB_DATA_W-1:0] data_q;
  uart_size              size_q;
  uart_freq              freq_q;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic [IDX_W-1:0]      lat_idx;
  logic [IDX_W-1:0]      ptr_d;
  logic [ARB_DATA_W-1:0] data_d;
  uart_size              size_d;
  uart_freq              freq_d;
  logic                  relock;

  rr_pick #(.N(N)) u_pick (
    .valid_i (bus.i_req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

`ifdef UART_TX_ARB_LOCK_EN
  assign relock = bus.i_req_lock[winner_q] & bus.i_req_valid[winner_q];
`else
  logic unused_lock;
  assign unused_lock = ^bus.i_req_lock;
  assign relock      = 1'b0;
`endif

  // A re-grant latches the current owner's next frame; otherwise the search result.
  assign lat_idx = (state_q == ARB_WAIT) ? winner_q : pick_idx;
  assign data_d  = bus.i_req_data[int'(lat_idx)*ARB_DATA_W +: ARB_DATA_W];
  assign size_d  = uart_size'(bus.i_req_size[int'(lat_idx)*ARB_SIZE_W +: ARB_SIZE_W]);
  assign freq_d  = uart_freq'(bus.i_req_freq[int'(lat_idx)*FW +: FW]);
  assign ptr_d   = (winner_q == IDX_W'(N - 1)) ? '0 : winner_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      grant_q  <= '0;
      ready_q  <= '0;
      busy_q   <= 1'b0;
      we_q     <= 1'b0;
      data_q   <= '0;
      size_q   <= uart_8;
      freq_q   <= uart_freq'(0);
    end else begin
      we_q    <= 1'b0;
      ready_q <= '0;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            winner_q <= pick_idx;
            data_q   <= data_d;
            size_q   <= size_d;
            freq_q   <= freq_d;
            grant_q  <= N'(1) << pick_idx;
            busy_q   <= 1'b1;
            state_q  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          we_q    <= 1'b1;
          ready_q <= grant_q;
          state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // we_q is high only in the first WAIT cycle, where a leftover done is ignored.
          if (!we_q && bus.i_tx_done) begin
            if (relock) begin
              data_q  <= data_d;
              size_q  <= size_d;
              freq_q  <= freq_d;
              state_q <= ARB_ISSUE;
            end else begin
              ptr_q   <= ptr_d;
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = ready_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_tx_we     = we_q;
  assign bus.o_tx_data   = data_q;
  assign bus.o_tx_size   = size_q;
  assign bus.o_tx_freq   = freq_q;
  assign bus.o_dbg_state = state_q;
  assign bus.o_dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a round-robin reference model and a frame scoreboard.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int FW = $bits(uart_freq);
  localparam int F  = 12 + FW;   // {freq, size, data}
  localparam int W  = 3 + F;     // {requester index, frame}

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.N(N)) arb_if ();

  uart_tx_arbiter #(.N(N)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (arb_if.master)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [F-1:0] req_mem [N][8];
  int           req_head[N];
  int           req_cnt [N];
  int           model_ptr;
  logic [W-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic apply_reqs();
    logic [F-1:0] f;
    for (int k = 0; k < N; k++) begin
      f = (req_cnt[k] > 0) ? req_mem[k][req_head[k]] : '0;
      arb_if.i_req_valid[k]         = (req_cnt[k] > 0);
      arb_if.i_req_data[k*9 +: 9]   = f[8:0];
      arb_if.i_req_size[k*3 +: 3]   = f[11:9];
      arb_if.i_req_freq[k*FW +: FW] = f[F-1:12];
    end
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      req_head[k] = 0;
      req_cnt[k]  = 0;
    end
    arb_if.i_req_lock = '0;
    arb_if.i_tx_done  = 1'b0;
    apply_reqs();
  endtask

  task automatic load(input int k, input logic [F-1:0] f);
    req_mem[k][req_head[k] + req_cnt[k]] = f;
    req_cnt[k]++;
  endtask

  function automatic logic [F-1:0] rand_frame();
    logic [8:0] d;
    logic [2:0] s;
    logic [FW-1:0] q;
    d = 9'($urandom_range(0, 511));
    s = 3'($urandom_range(0, 4));
    q = FW'($urandom_range(0, (1 << FW) - 1));
    return {q, s, d};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // ---------------- reference model ----------------
  // Service order: fresh picks scan from one past the last winner; a locked
  // requester 1 keeps the channel while it has frames and fewer than lock_frames sent.
  task automatic build_expected(input int lock_frames);
    int rem[N];
    int hd[N];
    int ptr, last, s1, w, total;
    bit relock;
    ptr = model_ptr; last = -1; s1 = 0; total = 0;
    for (int k = 0; k < N; k++) begin
      rem[k] = req_cnt[k];
      hd[k]  = req_head[k];
      total += rem[k];
    end
    exp_q.delete();
    while (total > 0) begin
      relock = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      relock = (last == 1) && (s1 < lock_frames) && (rem[1] > 0);
`endif
      if (relock) w = last;
      else begin
        w = -1;
        for (int o = 0; o < N; o++)
          if (w < 0 && rem[(ptr + o) % N] > 0) w = (ptr + o) % N;
      end
      exp_q.push_back({3'(w), req_mem[w][hd[w]]});
      hd[w]++; rem[w]--; total--;
      if (w == 1) s1++;
      last = w;
      ptr  = (w + 1) % N;
    end
    model_ptr = ptr;
  endtask

  // Acts as requesters and uart_tx; each o_tx_we is scored against exp_q.
  task automatic run_frames(input string tag, input int lock_frames);
    logic [W-1:0] e;
    logic [N-1:0] oh;
    int idx, guard, sent1;
    sent1 = 0;
    while (exp_q.size() > 0) begin
      guard = 0;
      while (arb_if.o_tx_we !== 1'b1 && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      n_cmp++;
      if (arb_if.o_tx_we !== 1'b1) begin
        n_err++;
        $display("FAIL %s tx_we_timeout: o_tx_we=%b required 1 within 40 cycles", tag, arb_if.o_tx_we);
        exp_q.delete();
        return;
      end
      e   = exp_q.pop_front();
      idx = int'(e[W-1 -: 3]);
      oh  = N'(1) << idx;
      n_cmp++;
      if ({arb_if.o_tx_freq, arb_if.o_tx_size, arb_if.o_tx_data} !== e[F-1:0]) begin
        n_err++;
        $display("FAIL %s frame: got %h required %h (req %0d)", tag,
                 {arb_if.o_tx_freq, arb_if.o_tx_size, arb_if.o_tx_data}, e[F-1:0], idx);
      end
      n_cmp++;
      if (arb_if.o_req_ready !== oh || arb_if.o_grant !== oh || arb_if.o_busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s ready_grant: ready=%b grant=%b busy=%b required ready=grant=%b busy=1",
                 tag, arb_if.o_req_ready, arb_if.o_grant, arb_if.o_busy, oh);
      end
      for (int k = 0; k < N; k++) begin
        if (arb_if.o_req_ready[k] === 1'b1 && req_cnt[k] > 0) begin
          req_head[k]++;
          req_cnt[k]--;
          if (k == 1) sent1++;
        end
      end
      if (lock_frames > 0) arb_if.i_req_lock = (sent1 < lock_frames) ? N'(2) : '0;
      apply_reqs();
      @(negedge clk);
      n_cmp++;
      if (arb_if.o_tx_we !== 1'b0 || arb_if.o_req_ready !== '0) begin
        n_err++;
        $display("FAIL %s pulse_width: we=%b ready=%b required 0 and 0", tag, arb_if.o_tx_we, arb_if.o_req_ready);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      arb_if.i_tx_done = 1'b1;
      @(negedge clk);
      arb_if.i_tx_done = 1'b0;
      n_cmp++;
`ifdef UART_TX_ARB_LOCK_EN
      if (idx == 1 && sent1 < lock_frames && req_cnt[1] > 0) begin
        if (arb_if.o_busy !== 1'b1 || arb_if.o_grant !== oh) begin
          n_err++;
          $display("FAIL %s relock: busy=%b grant=%b required 1 and %b", tag, arb_if.o_busy, arb_if.o_grant, oh);
        end
      end else
`endif
      begin
        if (arb_if.o_busy !== 1'b0 || arb_if.o_grant !== '0) begin
          n_err++;
          $display("FAIL %s release: busy=%b grant=%b required 0 and 0", tag, arb_if.o_busy, arb_if.o_grant);
        end
      end
    end
    n_cmp++;
    if (int'(arb_if.o_dbg_ptr) !== model_ptr) begin
      n_err++;
      $display("FAIL %s end_ptr: ptr=%0d required %0d", tag, arb_if.o_dbg_ptr, model_ptr);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (arb_if.o_tx_we !== 1'b0 || arb_if.o_req_ready !== '0 || arb_if.o_grant !== '0 || arb_if.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: we=%b ready=%b grant=%b busy=%b required all 0",
               arb_if.o_tx_we, arb_if.o_req_ready, arb_if.o_grant, arb_if.o_busy);
    end
    n_cmp++;
    if (arb_if.o_tx_data !== 9'd0 || arb_if.o_tx_size !== uart_8 || arb_if.o_tx_freq !== uart_freq'(0)) begin
      n_err++;
      $display("FAIL reset_data: data=%h size=%0d freq=%0d required 0/3/0",
               arb_if.o_tx_data, arb_if.o_tx_size, arb_if.o_tx_freq);
    end
    n_cmp++;
    if (arb_if.o_dbg_state !== ARB_IDLE || arb_if.o_dbg_ptr !== '0) begin
      n_err++;
      $display("FAIL reset_state: state=%0d ptr=%0d required 0/0", arb_if.o_dbg_state, arb_if.o_dbg_ptr);
    end
  endtask

  task automatic test_single_latency();
    logic [FW-1:0] q;
    do_reset();
    q = FW'($urandom_range(0, (1 << FW) - 1));
    load(2, {q, 3'd3, 9'h0A5});
    apply_reqs();
    @(negedge clk);
    n_cmp++;
    if (arb_if.o_tx_we !== 1'b0 || arb_if.o_grant !== 4'b0100 || arb_if.o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_issue: we=%b grant=%b busy=%b required 0/0100/1", arb_if.o_tx_we, arb_if.o_grant, arb_if.o_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (arb_if.o_tx_we !== 1'b1 || arb_if.o_req_ready !== 4'b0100 || arb_if.o_tx_data !== 9'h0A5
        || arb_if.o_tx_size !== uart_8 || arb_if.o_tx_freq !== uart_freq'(q)) begin
      n_err++;
      $display("FAIL single_we: we=%b ready=%b data=%h size=%0d freq=%0d required 1/0100/0a5/3/%0d",
               arb_if.o_tx_we, arb_if.o_req_ready, arb_if.o_tx_data, arb_if.o_tx_size, arb_if.o_tx_freq, q);
    end
    clear_reqs();
    @(negedge clk);
    n_cmp++;
    if (arb_if.o_tx_we !== 1'b0 || arb_if.o_req_ready !== '0 || arb_if.o_grant !== 4'b0100) begin
      n_err++;
      $display("FAIL single_hold: we=%b ready=%b grant=%b required 0/0000/0100", arb_if.o_tx_we, arb_if.o_req_ready, arb_if.o_grant);
    end
    arb_if.i_tx_done = 1'b1;
    @(negedge clk);
    arb_if.i_tx_done = 1'b0;
    n_cmp++;
    if (arb_if.o_grant !== '0 || arb_if.o_busy !== 1'b0 || arb_if.o_dbg_ptr !== 2'd3) begin
      n_err++;
      $display("FAIL single_done: grant=%b busy=%b ptr=%0d required 0000/0/3", arb_if.o_grant, arb_if.o_busy, arb_if.o_dbg_ptr);
    end
    model_ptr = 3;
  endtask

  task automatic test_wrap();
    load(0, rand_frame());
    load(2, rand_frame());
    apply_reqs();
    build_expected(0);
    run_frames("wrap", 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < N; k++) begin
      load(k, rand_frame());
      load(k, rand_frame());
    end
    apply_reqs();
    build_expected(0);
    run_frames("back_to_back", 0);
  endtask

  task automatic test_stale_done();
    do_reset();
    load(0, rand_frame());
    arb_if.i_tx_done = 1'b1;
    apply_reqs();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (arb_if.o_tx_we !== 1'b1) begin
      n_err++;
      $display("FAIL stale_we: we=%b required 1", arb_if.o_tx_we);
    end
    clear_reqs();
    arb_if.i_tx_done = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (arb_if.o_dbg_state !== ARB_WAIT || arb_if.o_busy !== 1'b1 || arb_if.o_grant !== 4'b0001) begin
      n_err++;
      $display("FAIL stale_guard: state=%0d busy=%b grant=%b required 2/1/0001", arb_if.o_dbg_state, arb_if.o_busy, arb_if.o_grant);
    end
    @(negedge clk);
    arb_if.i_tx_done = 1'b0;
    n_cmp++;
    if (arb_if.o_dbg_state !== ARB_IDLE || arb_if.o_busy !== 1'b0 || arb_if.o_grant !== '0) begin
      n_err++;
      $display("FAIL stale_exit: state=%0d busy=%b grant=%b required 0/0/0000", arb_if.o_dbg_state, arb_if.o_busy, arb_if.o_grant);
    end
    model_ptr = 1;
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    load(1, rand_frame() | {{(F-1){1'b0}}, 1'b1});
    apply_reqs();
    guard = 0;
    while (arb_if.o_tx_we !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (arb_if.o_tx_we !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_we: we=%b required 1", arb_if.o_tx_we);
    end
    clear_reqs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (arb_if.o_tx_we !== 1'b0 || arb_if.o_req_ready !== '0 || arb_if.o_grant !== '0 || arb_if.o_busy !== 1'b0
        || arb_if.o_tx_data !== 9'd0 || arb_if.o_tx_size !== uart_8 || arb_if.o_tx_freq !== uart_freq'(0)) begin
      n_err++;
      $display("FAIL midreset_out: we=%b ready=%b grant=%b busy=%b data=%h size=%0d freq=%0d required reset values",
               arb_if.o_tx_we, arb_if.o_req_ready, arb_if.o_grant, arb_if.o_busy,
               arb_if.o_tx_data, arb_if.o_tx_size, arb_if.o_tx_freq);
    end
    n_cmp++;
    if (arb_if.o_dbg_state !== ARB_IDLE || arb_if.o_dbg_ptr !== '0) begin
      n_err++;
      $display("FAIL midreset_state: state=%0d ptr=%0d required 0/0", arb_if.o_dbg_state, arb_if.o_dbg_ptr);
    end
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 4; i++) load(1, rand_frame());
    for (int i = 0; i < 2; i++) load(3, rand_frame());
    arb_if.i_req_lock = 4'b0010;
    apply_reqs();
    build_expected(3);
    run_frames("lock", 3);
    arb_if.i_req_lock = '0;
  endtask

  task automatic test_random();
    int total;
    for (int r = 0; r < 4; r++) begin
      total = 0;
      for (int k = 0; k < N; k++) begin
        for (int i = $urandom_range(0, 3); i > 0; i--) begin
          load(k, rand_frame());
          total++;
        end
      end
      if (total == 0) load($urandom_range(0, N - 1), rand_frame());
      apply_reqs();
      build_expected(0);
      run_frames("random", 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    clear_reqs();
    test_reset();
    test_single_latency();
    test_wrap();
    test_back_to_back();
    test_stale_done();
    test_reset_mid_frame();
    test_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
